// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared constants and helpers for the N-master bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_arb_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // Index width that never collapses to zero bits for tiny inputs.
    function automatic int clog2_safe(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_picker.sv
`default_nettype none
// ============================================================================
//  Module      : arb_picker
//  Description : Combinational winner selection: rotate, priority-encode, un-rotate.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = clog2_safe(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_W-1:0]        last_id,
    input  logic                   mode,
    output logic                   valid,
    output logic [ID_W-1:0]        winner_id
);

    localparam int              SUM_W  = ID_W + 1;
    localparam logic [SUM_W-1:0] c_num  = SUM_W'(NUM_MASTERS);
    localparam logic [ID_W-1:0]  c_last = ID_W'(NUM_MASTERS - 1);

    logic [ID_W-1:0]        w_start;
    logic [NUM_MASTERS-1:0] w_rot;
    logic [SUM_W-1:0]       w_sum;
    logic [ID_W-1:0]        w_pos;
    logic [SUM_W-1:0]       w_unrot;

    always_comb begin
        w_start = '0;
        if (mode == ARB_RR && last_id != c_last) begin
            w_start = last_id + 1'b1;
        end

        // Position i of the rotated vector holds master (start + i) mod N.
        w_rot = '0;
        w_sum = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_sum = {1'b0, w_start} + SUM_W'(i);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            w_rot[i] = req[w_sum[ID_W-1:0]];
        end

        w_pos = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = ID_W'(i);
            end
        end

        w_unrot = {1'b0, w_start} + {1'b0, w_pos};
        if (w_unrot >= c_num) begin
            w_unrot = w_unrot - c_num;
        end

        valid     = |w_rot;
        winner_id = w_unrot[ID_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_n
//  Description : N-master bus arbiter with bounded tenure, preemption and a
//                dead cycle on every handover; drives the bus to zero when idle.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter bit RR_MODE     = 1'b1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_MASTERS-1:0]       req,
    output logic [NUM_MASTERS-1:0]       grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                         bus_busy,
    inout  wire  [ADDR_W-1:0]            addr_bus,
    inout  wire  [DATA_W-1:0]            data_bus,
    inout  wire                          wr_bus,
    inout  wire                          rd_bus,
    inout  wire                          fc_bus,
    inout  wire  [DATA_W/8-1:0]          data_mask_bus
);

    localparam int               ID_W        = clog2_safe(NUM_MASTERS);
    localparam int               CNT_W       = clog2_safe(MAX_HOLD + 1);
    localparam logic [ID_W-1:0]  c_last      = ID_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);
    localparam logic             c_mode      = RR_MODE ? ARB_RR : ARB_FIXED;

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        r_last_id;
    logic [CNT_W-1:0]       r_count;
    logic                   r_preempted;

    logic [NUM_MASTERS-1:0] w_win_oh;
    logic [NUM_MASTERS-1:0] w_last_oh;
    logic [NUM_MASTERS-1:0] w_req_alt;
    logic [NUM_MASTERS-1:0] w_req_eff;
    logic                   w_valid;
    logic [ID_W-1:0]        w_winner_id;
    logic                   w_holder_req;
    logic                   w_others;
    logic                   w_preempt;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_decode
        assign w_win_oh[gi]  = (w_winner_id == ID_W'(gi));
        assign w_last_oh[gi] = (r_last_id == ID_W'(gi));
    end

    // A just-preempted holder sits out the re-arbitration unless nobody else still wants the bus.
    assign w_req_alt = req & ~w_last_oh;
    assign w_req_eff = (r_preempted && (|w_req_alt)) ? w_req_alt : req;

    arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_picker (
        .req       (w_req_eff),
        .last_id   (r_last_id),
        .mode      (c_mode),
        .valid     (w_valid),
        .winner_id (w_winner_id)
    );

    assign w_holder_req = |(req & r_grant);
    assign w_others     = |(req & ~r_grant);
    assign w_preempt    = (MAX_HOLD != 0) && (r_count >= c_hold_last) && w_others;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_id  <= '0;
            r_last_id   <= c_last;
            r_count     <= '0;
            r_preempted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_TURN: begin
                    r_preempted <= 1'b0;
                    if (w_valid) begin
                        r_state    <= ST_GRANT;
                        r_grant    <= w_win_oh;
                        r_grant_id <= w_winner_id;
                        r_last_id  <= w_winner_id;
                        r_count    <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (r_count != c_cnt_max) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (!w_holder_req || w_preempt) begin
                        r_grant     <= '0;
                        r_grant_id  <= '0;
                        r_state     <= w_others ? ST_TURN : ST_IDLE;
                        r_preempted <= w_holder_req;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_grant     <= '0;
                    r_grant_id  <= '0;
                    r_preempted <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign bus_busy = |r_grant;

    assign addr_bus      = bus_busy ? {ADDR_W{1'bz}}   : '0;
    assign data_bus      = bus_busy ? {DATA_W{1'bz}}   : '0;
    assign wr_bus        = bus_busy ? 1'bz             : 1'b0;
    assign rd_bus        = bus_busy ? 1'bz             : 1'b0;
    assign fc_bus        = bus_busy ? 1'bz             : 1'b0;
    assign data_mask_bus = bus_busy ? {(DATA_W/8){1'bz}} : '0;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_n
//  Description : Directed bench for bus_arbiter_n (RR, fixed, unlimited-hold instances).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       drv_en;
    logic [3:0] rr_req, fx_req;
    logic [1:0] un_req;
    logic [3:0] rr_grant, fx_grant;
    logic [1:0] un_grant;
    logic [1:0] rr_id, fx_id;
    logic       un_id;
    logic       rr_busy, fx_busy, un_busy;

    wire [31:0] rr_addr, rr_data, fx_addr, fx_data, un_addr, un_data;
    wire        rr_wr, rr_rd, rr_fc, fx_wr, fx_rd, fx_fc, un_wr, un_rd, un_fc;
    wire [3:0]  rr_mask, fx_mask, un_mask;

    // Master 1 of the RR instance drives the address bus while it holds the grant.
    assign rr_addr = (drv_en && rr_grant[1]) ? 32'hA5A5_1234 : 32'hzzzz_zzzz;

    int n_pass  = 0;
    int n_total = 0;

    bus_arbiter_n #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(rr_req), .grant(rr_grant), .grant_id(rr_id), .bus_busy(rr_busy),
        .addr_bus(rr_addr), .data_bus(rr_data), .wr_bus(rr_wr), .rd_bus(rr_rd), .fc_bus(rr_fc),
        .data_mask_bus(rr_mask));

    bus_arbiter_n #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b0), .MAX_HOLD(4)) u_fx (
        .clk(clk), .rst(rst), .req(fx_req), .grant(fx_grant), .grant_id(fx_id), .bus_busy(fx_busy),
        .addr_bus(fx_addr), .data_bus(fx_data), .wr_bus(fx_wr), .rd_bus(fx_rd), .fc_bus(fx_fc),
        .data_mask_bus(fx_mask));

    bus_arbiter_n #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1), .MAX_HOLD(0)) u_un (
        .clk(clk), .rst(rst), .req(un_req), .grant(un_grant), .grant_id(un_id), .bus_busy(un_busy),
        .addr_bus(un_addr), .data_bus(un_data), .wr_bus(un_wr), .rd_bus(un_rd), .fc_bus(un_fc),
        .data_mask_bus(un_mask));

    task automatic test_reset();
        rst = 1'b1; drv_en = 1'b0;
        rr_req = '0; fx_req = '0; un_req = '0;
        repeat (3) @(negedge clk);
        n_total++; if (rr_grant !== 4'b0000) $display("FAIL reset_grant: got %b expected %b", rr_grant, 4'b0000); else n_pass++;
        n_total++; if (rr_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", rr_id); else n_pass++;
        n_total++; if (rr_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rr_busy); else n_pass++;
        n_total++; if (rr_addr !== 32'h0 || rr_data !== 32'h0) $display("FAIL reset_bus: got addr %h data %h expected 0", rr_addr, rr_data); else n_pass++;
        n_total++; if ({rr_wr, rr_rd, rr_fc, rr_mask} !== 7'b0) $display("FAIL reset_strobes: got %b expected 0", {rr_wr, rr_rd, rr_fc, rr_mask}); else n_pass++;
        n_total++; if (fx_grant !== 4'b0000 || un_grant !== 2'b00) $display("FAIL reset_others: got %b/%b expected 0", fx_grant, un_grant); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        rr_req = 4'b0010; drv_en = 1'b1;
        #1;
        n_total++; if (rr_grant !== 4'b0000) $display("FAIL single_no_comb: got %b expected %b", rr_grant, 4'b0000); else n_pass++;
        n_total++; if (rr_addr !== 32'h0) $display("FAIL single_bus_idle: got %h expected 0", rr_addr); else n_pass++;
        @(negedge clk);
        n_total++; if (rr_grant !== 4'b0010) $display("FAIL single_grant: got %b expected %b", rr_grant, 4'b0010); else n_pass++;
        n_total++; if (rr_id !== 2'd1) $display("FAIL single_id: got %0d expected 1", rr_id); else n_pass++;
        n_total++; if (rr_busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", rr_busy); else n_pass++;
        n_total++; if (rr_addr !== 32'hA5A5_1234) $display("FAIL single_bus_released: got %h expected a5a51234", rr_addr); else n_pass++;
    endtask

    task automatic test_release();
        rr_req = 4'b0000;
        @(negedge clk);
        n_total++; if (rr_grant !== 4'b0000) $display("FAIL release_grant: got %b expected %b", rr_grant, 4'b0000); else n_pass++;
        n_total++; if (rr_id !== 2'd0 || rr_busy !== 1'b0) $display("FAIL release_id_busy: got %0d/%b expected 0/0", rr_id, rr_busy); else n_pass++;
        n_total++; if (rr_addr !== 32'h0) $display("FAIL release_bus: got %h expected 0", rr_addr); else n_pass++;
        drv_en = 1'b0;
        @(negedge clk);
        n_total++; if (rr_grant !== 4'b0000) $display("FAIL release_stay_idle: got %b expected %b", rr_grant, 4'b0000); else n_pass++;
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_g;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rr_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_total++; if (rr_grant !== exp_g || rr_id !== 2'(k % 4))
                    $display("FAIL rr_tenure k=%0d c=%0d: got %b id %0d expected %b id %0d", k, c, rr_grant, rr_id, exp_g, k % 4);
                else n_pass++;
            end
            @(negedge clk);
            n_total++; if (rr_grant !== 4'b0000 || rr_data !== 32'h0)
                $display("FAIL rr_turn k=%0d: got %b data %h expected 0000 data 0", k, rr_grant, rr_data);
            else n_pass++;
        end
        rr_req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        fx_req = 4'b0110;
        @(negedge clk);
        n_total++; if (fx_grant !== 4'b0010) $display("FAIL fixed_first: got %b expected %b", fx_grant, 4'b0010); else n_pass++;
        fx_req = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++; if (fx_grant !== 4'b0010) $display("FAIL fixed_keep c=%0d: got %b expected %b", c, fx_grant, 4'b0010); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (fx_grant !== 4'b0000) $display("FAIL fixed_preempt_turn: got %b expected %b", fx_grant, 4'b0000); else n_pass++;
        @(negedge clk);
        n_total++; if (fx_grant !== 4'b0001 || fx_id !== 2'd0) $display("FAIL fixed_m0_wins: got %b id %0d expected 0001 id 0", fx_grant, fx_id); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (fx_grant !== 4'b0001) $display("FAIL fixed_m0_tenure: got %b expected %b", fx_grant, 4'b0001); else n_pass++;
        @(negedge clk);
        n_total++; if (fx_grant !== 4'b0000) $display("FAIL fixed_m0_turn: got %b expected %b", fx_grant, 4'b0000); else n_pass++;
        @(negedge clk);
        n_total++; if (fx_grant !== 4'b0010 || fx_id !== 2'd1) $display("FAIL fixed_m0_yields: got %b id %0d expected 0010 id 1", fx_grant, fx_id); else n_pass++;
        fx_req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_unlimited();
        int held;
        un_req = 2'b01;
        @(negedge clk);
        n_total++; if (un_grant !== 2'b01) $display("FAIL unl_first: got %b expected %b", un_grant, 2'b01); else n_pass++;
        un_req = 2'b11;
        held = 0;
        repeat (100) begin
            @(negedge clk);
            if (un_grant === 2'b01) held++;
        end
        n_total++; if (held != 100) $display("FAIL unl_hold: got %0d cycles expected 100", held); else n_pass++;
        un_req = 2'b10;
        @(negedge clk);
        n_total++; if (un_grant !== 2'b00) $display("FAIL unl_turn: got %b expected %b", un_grant, 2'b00); else n_pass++;
        @(negedge clk);
        n_total++; if (un_grant !== 2'b10 || un_id !== 1'b1) $display("FAIL unl_handover: got %b id %0d expected 10 id 1", un_grant, un_id); else n_pass++;
        un_req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rr_req = 4'b0100;
        @(negedge clk);
        n_total++; if (rr_grant !== 4'b0100) $display("FAIL midrst_pre: got %b expected %b", rr_grant, 4'b0100); else n_pass++;
        rst = 1'b1; rr_req = 4'b1111;
        @(negedge clk);
        n_total++; if (rr_grant !== 4'b0000 || rr_busy !== 1'b0) $display("FAIL midrst_drop: got %b busy %b expected 0000 busy 0", rr_grant, rr_busy); else n_pass++;
        n_total++; if (rr_addr !== 32'h0) $display("FAIL midrst_bus: got %h expected 0", rr_addr); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (rr_grant !== 4'b0001 || rr_id !== 2'd0) $display("FAIL midrst_next: got %b id %0d expected 0001 id 0", rr_grant, rr_id); else n_pass++;
        rr_req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_release();
        test_rr_fairness();
        test_fixed();
        test_unlimited();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
